fifo0_depth_n: RTL
==================

// Module: fifo0_depth_n
// PURPOSE
//   Data-less (token) FIFO of parametrised depth; generalises the depth-1, width-0 FIFO.
//   Tracks outstanding tokens with an occupancy counter.
//   Outputs registered full, empty, almost-full and count status for BSV-generated handshakes.
//   Used wherever only the occurrence of an event is queued, e.g. credit/ack tracking.
// PARAMETERS
//   DEPTH      4           max tokens held; legal range >= 1
//   AFULL_LVL  DEPTH-1     ALMOST_FULL_N deasserts when count >= AFULL_LVL; legal 1..DEPTH
//   GUARDED    1           1: ENQ on full is an error even with DEQ; 0: ENQ+DEQ on full is legal
//   CNT_W      derived     localparam = clog2(DEPTH+1); not overridable
// PORTS
//   CLK            in   1      clock, all state on rising edge
//   RST_N          in   1      reset, synchronous, active-low
//   ENQ            in   1      enqueue one token
//   DEQ            in   1      dequeue one token
//   CLR            in   1      synchronous clear; highest priority after reset
//   FULL_N         out  1      1 = count < DEPTH
//   EMPTY_N        out  1      1 = count != 0
//   ALMOST_FULL_N  out  1      1 = count < AFULL_LVL
//   COUNT          out  CNT_W  current occupancy, 0..DEPTH
//   ERR            out  1      sticky overflow/underflow flag (see CONFIGURATION)
// BEHAVIOUR
//   - Reset (RST_N=0 at edge): count=0, EMPTY_N=0, FULL_N=1, ALMOST_FULL_N=1, ERR=0.
//   - Priority per edge: RST_N low > CLR > ENQ/DEQ update. CLR: count=0, ERR=0.
//   - eff_deq = DEQ && count!=0.
//   - eff_enq = ENQ && (count!=DEPTH || DEQ); ENQ takes priority at both boundaries.
//   - next count = count + eff_enq - eff_deq; never wraps, stays within 0..DEPTH.
//   - Empty + ENQ + DEQ: DEQ ignored; count becomes 1.
//   - Full + ENQ + DEQ: count stays DEPTH; the token passes through.
//   - Full + ENQ alone: ENQ dropped, count unchanged. Empty + DEQ alone: ignored.
//   - Latency: status outputs reflect an ENQ/DEQ one cycle after the edge.
//   - No combinational path from any input to any output.
//   - All flags are registers updated in the same cycle as count, consistent with next count.
//   - DEPTH=1 is cycle-exact to the legacy depth-1 token FIFO; ALMOST_FULL_N equals FULL_N.
//   - Reset or CLR mid-stream discards all tokens; ENQ in the same cycle is ignored.
// CONFIGURATION
//   Macro FIFO0_ERR_CHECK_EN:
//   - Defined: ERR sets one cycle after a non-CLR, non-reset edge with either
//     underflow (DEQ && count==0) or overflow (ENQ && count==DEPTH && (!DEQ || GUARDED)).
//     ERR is cleared only by reset or CLR.
//     Sim-only $display warnings give the instance path and error kind (excluded from synthesis).
//   - Undefined: ERR tied 0; no checking logic, no messages.
//   Count/flag behaviour is identical in both cases.
// STRUCTURE
//   Package fifo0_pkg:
//   - constant function fifo0_clog2(n);
//   - typedef enum {FIFO0_ERR_NONE, FIFO0_ERR_UNDER, FIFO0_ERR_OVER} used by the checker.
//   Sub-module fifo0_err_mon (only instantiated under FIFO0_ERR_CHECK_EN):
//   - inputs: ENQ, DEQ, CLR, count, full, empty;
//   - output: sticky ERR plus messages.
//   The counter and flag registers live in fifo0_depth_n itself.
// TESTING (DEPTH=4, AFULL_LVL=3, GUARDED=1, macro defined unless noted)
//   1. Reset then 4x ENQ -> COUNT 1,2,3,4.
//      ALMOST_FULL_N=0 from count 3; FULL_N=0 at 4; EMPTY_N=1 after first ENQ; ERR=0.
//   2. Full, 5th ENQ -> COUNT stays 4, ERR=1 next cycle; CLR -> COUNT=0, ERR=0, EMPTY_N=0.
//   3. Empty, ENQ+DEQ same cycle -> COUNT=1.
//      Count 2, ENQ+DEQ -> stays 2. Full, ENQ+DEQ -> stays 4, ERR=1 (GUARDED).
//      With GUARDED=0, the full ENQ+DEQ case leaves ERR=0.
//   4. Empty, DEQ alone -> COUNT 0, ERR=1.
//      Rebuild with macro undefined -> ERR stays 0 throughout.
//   5. Fill to 3, assert RST_N=0 together with ENQ -> COUNT=0, FULL_N=1, EMPTY_N=0 next cycle.
//   6. DEPTH=1 build, random ENQ/DEQ/CLR for 10k cycles -> EMPTY_N/FULL_N match
//      legacy depth-1 token FIFO cycle-for-cycle.

Source files
------------

// File: rtl/fifo0_pkg.sv
// rtl/fifo0_pkg.sv - shared constants, width helper and error kinds for the token FIFO
package fifo0_pkg;

   // Error kinds reported by the overflow/underflow checker
   typedef enum logic [1:0] {
      FIFO0_ERR_NONE  = 2'd0,
      FIFO0_ERR_UNDER = 2'd1,
      FIFO0_ERR_OVER  = 2'd2
   } fifo0_err_e;

   // Bits needed to hold values 0..n-1; used as clog2(DEPTH+1) for the counter
   function automatic int fifo0_clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/fifo0_err_mon.sv
// rtl/fifo0_err_mon.sv - sticky overflow/underflow flag for the token FIFO, with sim-only messages
module fifo0_err_mon
   import fifo0_pkg::*;
#(
   parameter bit GUARDED = 1'b1,
   parameter int CNT_W   = 3
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_enq,
   input  logic             i_deq,
   input  logic             i_clr,
   input  logic [CNT_W-1:0] i_count,
   input  logic             i_full,
   input  logic             i_empty,
   output logic             o_err
);

   fifo0_err_e w_kind;
   logic       r_err;

   // Classify this cycle's request; a full FIFO with ENQ+DEQ is only legal when unguarded
   always_comb begin
      w_kind = FIFO0_ERR_NONE;
      if (i_deq && i_empty) begin
         w_kind = FIFO0_ERR_UNDER;
      end else if (i_enq && i_full && (!i_deq || GUARDED)) begin
         w_kind = FIFO0_ERR_OVER;
      end
   end

   // Sticky flag: only reset or CLR clears it, and those edges never set it
   always_ff @(posedge i_clk) begin
      if (!i_rst_n || i_clr) begin
         r_err <= 1'b0;
      end else if (w_kind != FIFO0_ERR_NONE) begin
         r_err <= 1'b1;
      end
   end

`ifndef SYNTHESIS
   // Report each offending edge with the instance path and the kind of error
   always_ff @(posedge i_clk) begin
      if (i_rst_n && !i_clr && (w_kind != FIFO0_ERR_NONE)) begin
         $display("%m: token fifo %s at count %0d", w_kind.name(), i_count);
      end
   end
`endif

   assign o_err = r_err;

endmodule

// File: rtl/fifo0_depth_n.sv
// rtl/fifo0_depth_n.sv - data-less token FIFO of depth DEPTH; FIFO0_ERR_CHECK_EN enables the ERR checker
module fifo0_depth_n
   import fifo0_pkg::*;
#(
   parameter int  DEPTH     = 4,
   parameter int  AFULL_LVL = DEPTH - 1,
   parameter bit  GUARDED   = 1'b1,
   localparam int CNT_W     = fifo0_clog2(DEPTH + 1)
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             ENQ,
   input  logic             DEQ,
   input  logic             CLR,
   output logic             FULL_N,
   output logic             EMPTY_N,
   output logic             ALMOST_FULL_N,
   output logic [CNT_W-1:0] COUNT,
   output logic             ERR
);

   // The default AFULL_LVL is 0 for DEPTH=1; lifting it to 1 makes ALMOST_FULL_N track FULL_N there
   localparam int AF_EFF = (AFULL_LVL < 1) ? 1 : AFULL_LVL;

   logic [CNT_W-1:0] r_count;
   logic             r_full_n;
   logic             r_empty_n;
   logic             r_afull_n;
   logic             w_eff_enq;
   logic             w_eff_deq;
   logic [CNT_W-1:0] w_cnt_nxt;

   // DEQ on empty is ignored; ENQ on full only lands when a DEQ frees the slot in the same cycle
   assign w_eff_deq = DEQ && r_empty_n;
   assign w_eff_enq = ENQ && (r_full_n || DEQ);

   // Next occupancy; the effective enables keep it inside 0..DEPTH so it never wraps
   always_comb begin
      w_cnt_nxt = r_count;
      if (w_eff_enq && !w_eff_deq) begin
         w_cnt_nxt = r_count + 1'b1;
      end else if (!w_eff_enq && w_eff_deq) begin
         w_cnt_nxt = r_count - 1'b1;
      end
   end

   // Counter and status flags update together, flags computed from the next count
   always_ff @(posedge CLK) begin
      if (!RST_N || CLR) begin
         r_count   <= '0;
         r_full_n  <= 1'b1;
         r_empty_n <= 1'b0;
         r_afull_n <= 1'b1;
      end else begin
         r_count   <= w_cnt_nxt;
         r_full_n  <= (w_cnt_nxt != CNT_W'(DEPTH));
         r_empty_n <= (w_cnt_nxt != '0);
         r_afull_n <= (w_cnt_nxt < CNT_W'(AF_EFF));
      end
   end

`ifdef FIFO0_ERR_CHECK_EN
   fifo0_err_mon #(
      .GUARDED (GUARDED),
      .CNT_W   (CNT_W)
   ) u_err_mon (
      .i_clk   (CLK),
      .i_rst_n (RST_N),
      .i_enq   (ENQ),
      .i_deq   (DEQ),
      .i_clr   (CLR),
      .i_count (r_count),
      .i_full  (!r_full_n),
      .i_empty (!r_empty_n),
      .o_err   (ERR)
   );
`else
   assign ERR = 1'b0;
`endif

   assign COUNT         = r_count;
   assign FULL_N        = r_full_n;
   assign EMPTY_N       = r_empty_n;
   assign ALMOST_FULL_N = r_afull_n;

endmodule
